mac_dot_seq: RTL and testbench
==============================

MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand-pair FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter LEN_W, default 8, width of the vector-length field.
REQ-003 SHALL have clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have vec_len, input, LEN_W, number of (a,b) pairs in the next dot product.
REQ-006 SHALL have vec_start, input, 1, one-cycle pulse that begins a dot product.
REQ-007 SHALL have in_valid/in_ready, input/output, 1 each, operand-pair push handshake.
REQ-008 SHALL have in_a, in_b, input, 32 each, IEEE-754 single-precision operands.
REQ-009 SHALL have mac_start, output, 1, one-cycle start pulse to the downstream float_mac.
REQ-010 SHALL have mac_a, mac_b, mac_c, output, 32 each, float_mac operands (computes a*b+c).
REQ-011 SHALL have mac_result, input, 32, and mac_done, input, 1, float_mac result and completion pulse.
REQ-012 SHALL have out_valid/out_ready, output/input, 1 each, and out_data, output, 32, final dot-product result.
REQ-013 SHALL have busy, output, 1, high whenever the FSM is not IDLE.
REQ-014 SHALL have timeout, output, 1, high with out_valid when the result was aborted.

Function
REQ-015 The FIFO SHALL accept a pair when in_valid && in_ready; in_ready = !full, in any FSM state.
REQ-016 Simultaneous push and pop on a non-full, non-empty FIFO SHALL both occur, with occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, OUT.
REQ-018 In IDLE, vec_start with vec_len!=0 SHALL latch vec_len, clear the accumulator to 32'h00000000, clear the pair counter, and go to ISSUE.
REQ-019 In IDLE, vec_start with vec_len==0 SHALL go to OUT with out_data=32'h00000000.
REQ-020 vec_start outside IDLE SHALL be ignored.
REQ-021 In ISSUE with the FIFO non-empty, the block SHALL pop one pair, register mac_a=a, mac_b=b, mac_c=accumulator, assert mac_start for exactly one cycle, and go to WAIT.
REQ-022 mac_a, mac_b and mac_c SHALL hold stable from mac_start until the next mac_start, because float_mac samples c late.
REQ-023 In WAIT, mac_done SHALL load accumulator<=mac_result and increment the counter; if the counter then equals the latched length, the FSM SHALL go to OUT, otherwise to ISSUE.
REQ-024 mac_done outside WAIT SHALL be ignored.
REQ-025 In OUT, out_valid SHALL be high with out_data=accumulator held stable; on out_ready the FSM SHALL go to IDLE, and out_valid SHALL fall the next cycle.
REQ-026 Minimum latency from mac_done to the next mac_start SHALL be 2 cycles when the FIFO is non-empty.
REQ-027 The block SHALL perform no floating-point arithmetic itself; the accumulation is done only by the chained float_mac.

Reset
REQ-028 rst SHALL force IDLE, empty the FIFO, and zero the accumulator, counter and timer.
REQ-029 During reset, in_ready, mac_start, out_valid, busy and timeout SHALL be 0, and mac_a/b/c and out_data SHALL be 32'h0.
REQ-030 Reset asserted mid-operation SHALL abandon the vector; a later mac_done SHALL be ignored.

Configuration
REQ-031 With MAC_DOT_TIMEOUT_EN defined, an 8-bit timer SHALL count cycles in WAIT; reaching 255 without mac_done SHALL go to OUT with out_data=32'h7FC00000 and timeout=1.
REQ-032 Without MAC_DOT_TIMEOUT_EN, no timer SHALL exist, WAIT SHALL last until mac_done, and timeout SHALL be tied to 0.

Verification
REQ-033 Bench scenario: the bench uses a behavioural float_mac model, done 6 cycles after start. vec_len=2, pairs (3F800000,40000000), (40400000,40800000) -> mac_c=00000000 then 40000000; out_data=41600000; out_valid held until out_ready.
REQ-034 Bench scenario: vec_start with vec_len=0 -> no mac_start; out_valid next cycle with out_data=00000000.
REQ-035 Bench scenario: push 4 pairs with DEPTH=4 and no vec_start -> in_ready=0, a 5th push is refused; vec_start with len=4 -> all 4 consumed in FIFO order.
REQ-036 Bench scenario: rst for 1 cycle in WAIT, then a stray mac_done -> FSM stays IDLE, out_valid=0, and the FIFO is empty.
REQ-037 Bench scenario: with MAC_DOT_TIMEOUT_EN, suppress mac_done -> after 255 WAIT cycles out_valid=1, out_data=7FC00000, timeout=1; without the macro, busy stays 1.
REQ-038 Bench scenario: out_ready held low for 10 cycles in OUT -> out_data stable; a pending vec_start is ignored, and no second result is produced.

Source files
------------

// File: rtl/mac_dot_seq.sv
// mac_dot_seq -- sequences a dot product through an external float_mac.
//
// Purpose: buffers (a,b) operand pairs in a small FIFO and chains them through
//          a downstream float_mac (a*b+c), feeding each result back as the
//          next c, then presents the final sum on a valid/ready output.
// Latency: vec_start to first mac_start is 2 cycles with a pair already queued;
//          mac_done to the next mac_start is 2 cycles when the FIFO is non-empty.
// Backpressure: in_ready drops only when the FIFO is full; out_data is held
//          with out_valid until out_ready, and no new vector starts meanwhile.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   vec_len, vec_start           length and start pulse of the next dot product
//   in_valid/in_ready, in_a/in_b operand-pair push (IEEE-754 single)
//   mac_start, mac_a/b/c         operands and start pulse to float_mac
//   mac_result, mac_done         float_mac result and completion pulse
//   out_valid/out_ready/out_data final dot-product result
//   busy                         FSM is not IDLE
//   timeout                      result was aborted (only with the macro below)
//
// Optional feature: define MAC_DOT_TIMEOUT_EN to add an 8-bit WAIT timer that
// aborts a stalled float_mac after 255 cycles with a quiet-NaN result.

module mac_dot_seq #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             vec_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             mac_start,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic [31:0]      mac_c,
  input  logic [31:0]      mac_result,
  input  logic             mac_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic             timeout
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Operand-pair FIFO. Pointers are AW bits wide, so they wrap modulo DEPTH
  // (a power of two) on their own; the separate count disambiguates full/empty.
  // ---------------------------------------------------------------------------
  pair_t          fifo_mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_cnt;
  pair_t          wr_dat;
  pair_t          rd_dat;
  logic           rd_vld;
  logic           do_wr;
  logic           do_rd;
  state_t         state;

  assign wr_dat.a = in_a;
  assign wr_dat.b = in_b;
  // Gated by rst so the port reads 0 for the whole reset, not just after an edge.
  assign in_ready = !rst && (fifo_cnt != FULL_CNT);
  assign rd_vld   = (fifo_cnt != '0);
  assign rd_dat   = fifo_mem[rd_ptr];
  assign do_wr    = in_valid && in_ready;
  assign do_rd    = (state == ISSUE) && rd_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage has no reset: contents are only visible through rd_dat when count > 0.
  always_ff @(posedge clk) begin
    if (do_wr) fifo_mem[wr_ptr] <= wr_dat;
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // ---------------------------------------------------------------------------
  logic [31:0]      acc;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pair_cnt;
  logic [LEN_W-1:0] pair_cnt_nxt;

  assign pair_cnt_nxt = pair_cnt + LEN_W'(1);

`ifdef MAC_DOT_TIMEOUT_EN
  localparam logic [7:0]  TIMER_LAST = 8'd254;  // 255th WAIT cycle
  localparam logic [31:0] QNAN       = 32'h7FC00000;
  logic [7:0] timer;
  logic       timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      len_q     <= '0;
      pair_cnt  <= '0;
      mac_start <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_c     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
`ifdef MAC_DOT_TIMEOUT_EN
      timer     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      mac_start <= 1'b0;
      case (state)
        IDLE: begin
          if (vec_start) begin
            busy <= 1'b1;
            if (vec_len != '0) begin
              len_q    <= vec_len;
              acc      <= '0;
              pair_cnt <= '0;
              state    <= ISSUE;
            end else begin
              // Empty vector: the sum is +0.0 and no float_mac call is made.
              out_data  <= '0;
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        ISSUE: begin
          if (rd_vld) begin
            // mac_a/b/c stay untouched until the next pop, since float_mac
            // samples c several cycles after mac_start.
            mac_a     <= rd_dat.a;
            mac_b     <= rd_dat.b;
            mac_c     <= acc;
            mac_start <= 1'b1;
            state     <= WAIT;
`ifdef MAC_DOT_TIMEOUT_EN
            timer     <= '0;
`endif
          end
        end
        WAIT: begin
          if (mac_done) begin
            acc      <= mac_result;
            pair_cnt <= pair_cnt_nxt;
            if (pair_cnt_nxt == len_q) begin
              out_data  <= mac_result;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              state <= ISSUE;
            end
          end
`ifdef MAC_DOT_TIMEOUT_EN
          else if (timer == TIMER_LAST) begin
            out_data  <= QNAN;
            out_valid <= 1'b1;
            timeout_q <= 1'b1;
            state     <= OUT;
          end else begin
            timer <= timer + 8'd1;
          end
`endif
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
`ifdef MAC_DOT_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq -- self-checking bench for mac_dot_seq with a behavioural
// float_mac (integer-valued floats only, result 6 cycles after mac_start) and
// a transaction-level reference model of the expected dot products.

module tb_mac_dot_seq;

  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } tpair_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [LEN_W-1:0] vec_len;
  logic             vec_start;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             mac_start;
  logic [31:0]      mac_a;
  logic [31:0]      mac_b;
  logic [31:0]      mac_c;
  logic [31:0]      mac_result;
  logic             mac_done;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;
  logic             timeout;

  always #5 clk = ~clk;

  mac_dot_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .vec_len(vec_len), .vec_start(vec_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_result(mac_result), .mac_done(mac_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout(timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Non-negative integers < 2^24 to/from IEEE-754 single.
  function automatic logic [31:0] enc(input int unsigned n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (n[i]) e = i;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int unsigned dec(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    m = {8'h0, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  // ---------------- behavioural float_mac ----------------
  int          pend = 0;
  logic        suppress = 1'b0;
  logic        mdl_done = 1'b0;
  logic [31:0] mdl_res = 32'h0;
  assign mac_done   = mdl_done;
  assign mac_result = mdl_res;

  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (mac_start) pend = 5;
    else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0 && !suppress) begin
        mdl_done <= 1'b1;
        mdl_res  <= enc(dec(mac_a) * dec(mac_b) + dec(mac_c));
      end
    end
  end

  // ---------------- reference model + compare ----------------
  tpair_t      m_q[$];
  logic        m_active = 1'b0;
  int          m_len = 0;
  int          m_starts = 0;
  int          m_dones = 0;
  int unsigned m_acc = 0;
  logic        m_ov = 1'b0;
  logic [31:0] m_od = 32'h0;
  logic        m_to = 1'b0;
  int          m_wait = 0;
  logic        hold_vld = 1'b0;
  logic [31:0] hold_a, hold_b, hold_c;
  int          cyc = 0;
  int          gap_exp = -1;
  logic        chk_en = 1'b0;
  int          n_starts = 0;
  int          n_results = 0;
  logic [31:0] c_log[$];
  logic [31:0] res_log[$];

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      // Effects of the previous rising edge.
      if (mac_start) begin
        tpair_t p;
        n_starts++;
        chk("start_legal", {31'b0, m_active && m_starts == m_dones && m_starts < m_len}, 32'd1);
        if (gap_exp >= 0) chk("done_to_start_gap", cyc, gap_exp);
        gap_exp = -1;
        if (m_q.size() > 0) begin
          p = m_q.pop_front();
          chk("mac_a", mac_a, p.a);
          chk("mac_b", mac_b, p.b);
          chk("mac_c", mac_c, enc(m_acc));
          m_acc += dec(p.a) * dec(p.b);
        end else begin
          n_vec++;
          n_err++;
          $display("FAIL mac_pop: got mac_start with model FIFO empty, expected no pop");
        end
        c_log.push_back(mac_c);
        m_starts++;
        m_wait = 0;
        hold_vld = 1'b1;
        hold_a = mac_a;
        hold_b = mac_b;
        hold_c = mac_c;
      end else if (hold_vld) begin
        chk("mac_a_hold", mac_a, hold_a);
        chk("mac_b_hold", mac_b, hold_b);
        chk("mac_c_hold", mac_c, hold_c);
      end
      chk("in_ready", {31'b0, in_ready}, {31'b0, !rst && m_q.size() < DEPTH});
      chk("busy", {31'b0, busy}, {31'b0, m_active});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      chk("timeout", {31'b0, timeout}, {31'b0, m_to});
      if (m_ov) chk("out_data", out_data, m_od);

      // Events taking effect at the next rising edge.
      if (rst) begin
        m_q.delete();
        m_active = 1'b0;
        m_ov = 1'b0;
        m_to = 1'b0;
        m_starts = 0;
        m_dones = 0;
        m_acc = 0;
        hold_vld = 1'b0;
        gap_exp = -1;
      end else begin
        if (mac_done && m_active && m_dones < m_starts) begin
          m_dones++;
          if (m_dones == m_len) begin
            m_ov = 1'b1;
            m_od = enc(m_acc);
          end else if (m_q.size() > 0) begin
            gap_exp = cyc + 2;
          end
        end
`ifdef MAC_DOT_TIMEOUT_EN
        else if (m_active && !m_ov && m_starts > m_dones) begin
          m_wait++;
          if (m_wait == 255) begin
            m_ov = 1'b1;
            m_od = 32'h7FC00000;
            m_to = 1'b1;
          end
        end
`endif
        if (vec_start && !m_active) begin
          m_active = 1'b1;
          m_len = int'(vec_len);
          m_starts = 0;
          m_dones = 0;
          m_acc = 0;
          m_wait = 0;
          if (vec_len == '0) begin
            m_ov = 1'b1;
            m_od = 32'h0;
          end
        end else if (m_ov && out_ready) begin
          res_log.push_back(out_data);
          n_results++;
          m_active = 1'b0;
          m_ov = 1'b0;
          m_to = 1'b0;
        end
        if (in_valid && in_ready) m_q.push_back({in_a, in_b});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 500 && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL push_wait: got in_ready=0 for 500 cycles, expected acceptance");
    end
  endtask

  task automatic start(input int len);
    vec_len = LEN_W'(len);
    vec_start = 1'b1;
    tick();
    vec_start = 1'b0;
  endtask

  task automatic wait_ov;
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL out_wait: got out_valid=0 for 400 cycles, expected a result");
    end
  endtask

  task automatic wait_out(input int hold);
    wait_ov();
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, expected completion");
    $fatal(1);
  end

  initial begin
    int saved_s, saved_r, len, pre;
    rst = 1'b1; vec_start = 1'b0; vec_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;

    chk("enc_14", enc(14), 32'h41600000);
    chk("enc_35", enc(35), 32'h420C0000);
    chk("dec_4", dec(32'h40800000), 32'd4);

    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mac_start", {31'b0, mac_start}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    chk("rst_mac_a", mac_a, 32'h0);
    chk("rst_mac_c", mac_c, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    rst = 1'b0;
    tick();

    // Two-pair dot product: 1*2 + 3*4 = 14.
    c_log.delete();
    push(32'h3F800000, 32'h40000000);
    push(32'h40400000, 32'h40800000);
    start(2);
    wait_out(4);
    chk("s1_c0", (c_log.size() > 0) ? c_log[0] : 32'hDEADBEEF, 32'h00000000);
    chk("s1_c1", (c_log.size() > 1) ? c_log[1] : 32'hDEADBEEF, 32'h40000000);
    chk("s1_result", (res_log.size() > 0) ? res_log[res_log.size()-1] : 32'hDEADBEEF, 32'h41600000);

    // Zero-length vector.
    saved_s = n_starts;
    start(0);
    chk("len0_out_valid", {31'b0, out_valid}, 32'd1);
    chk("len0_out_data", out_data, 32'h0);
    wait_out(0);
    chk("len0_no_mac_start", n_starts, saved_s);

    // Fill the FIFO, refuse a fifth push, then consume in order.
    c_log.delete();
    push(enc(1), enc(1));
    push(enc(2), enc(2));
    push(enc(3), enc(3));
    push(enc(4), enc(4));
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1; in_a = enc(9); in_b = enc(9);
    tick();
    in_valid = 1'b0;
    start(4);
    wait_out(1);
    chk("full_c3", (c_log.size() > 3) ? c_log[3] : 32'hDEADBEEF, 32'h41600000);
    chk("full_result", (res_log.size() > 0) ? res_log[res_log.size()-1] : 32'hDEADBEEF, 32'h41F00000);

    // Result held for 10 cycles; a vec_start meanwhile is ignored.
    push(enc(6), enc(2));
    start(1);
    wait_ov();
    saved_r = n_results;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        vec_start = 1'b1; vec_len = 8'd1;
        in_valid = 1'b1; in_a = enc(2); in_b = enc(2);
      end
      tick();
      vec_start = 1'b0;
      in_valid = 1'b0;
    end
    chk("hold_out_data", out_data, 32'h41400000);
    saved_s = n_starts;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (20) tick();
    chk("hold_one_result", n_results, saved_r + 1);
    chk("hold_no_restart", n_starts, saved_s);

    // Reset in WAIT, stray mac_done afterwards.
    push(enc(1), enc(3));
    push(enc(2), enc(3));
    push(enc(3), enc(3));
    start(3);
    for (int i = 0; i < 50 && !mac_start; i++) tick();
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rstw_busy", {31'b0, busy}, 32'd0);
    chk("rstw_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rstw_in_ready", {31'b0, in_ready}, 32'd1);
    saved_s = n_starts;
    start(1);
    repeat (8) tick();
    chk("rstw_fifo_empty", n_starts, saved_s);
    push(32'h40A00000, 32'h40E00000);
    wait_out(0);
    chk("rstw_result", (res_log.size() > 0) ? res_log[res_log.size()-1] : 32'hDEADBEEF, 32'h420C0000);

    // Randomised vectors.
    for (int v = 0; v < 12; v++) begin
      len = $urandom_range(0, 6);
      pre = $urandom_range(0, (len < DEPTH) ? len : DEPTH);
      for (int k = 0; k < pre; k++) push(enc($urandom_range(0, 15)), enc($urandom_range(0, 15)));
      start(len);
      for (int k = pre; k < len; k++) push(enc($urandom_range(0, 15)), enc($urandom_range(0, 15)));
      wait_out($urandom_range(0, 3));
    end

    // Stalled float_mac.
    push(enc(2), enc(2));
    suppress = 1'b1;
    start(1);
`ifdef MAC_DOT_TIMEOUT_EN
    wait_ov();
    chk("to_out_data", out_data, 32'h7FC00000);
    chk("to_timeout", {31'b0, timeout}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    suppress = 1'b0;
`else
    repeat (300) tick();
    chk("stall_busy", {31'b0, busy}, 32'd1);
    chk("stall_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    suppress = 1'b0;
`endif
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
